regfile_wb_arbiter: RTL

Write-back arbiter and scoreboard for the 8-entry, 8-bit register file. It shares the register file's single write port between the ALU result path and the load path from data memory. It also tracks which registers have a write in flight, so issue logic can stall on RAW hazards and branch logic can stall on the comparison register (r7). It sits between the execute/memory stages and the register file's write_en/w_addr/data_in inputs.

---
 rtl/regfile_wb_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and scoreboard for the 8-entry register file.
// Shares the single register-file write port between the ALU result path
// and the load path. It also keeps per-register write-pending bits so that
// issue and branch logic can stall on outstanding producers.
module regfile_wb_arbiter #(
  parameter int W      = 8,  // data width
  parameter int D      = 3,  // register address width
  parameter int STARVE = 3   // lost-arbitration cycles before ALU gets priority (1..7)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic [D-1:0]     alu_addr,
  input  logic [W-1:0]     alu_data,
  output logic             alu_ready,
  input  logic             mem_valid,
  input  logic [D-1:0]     mem_addr,
  input  logic [W-1:0]     mem_data,
  output logic             mem_ready,
  input  logic             claim_en,
  input  logic [D-1:0]     claim_addr,
  output logic             rf_write_en,
  output logic [D-1:0]     rf_w_addr,
  output logic [W-1:0]     rf_data_in,
  output logic [2**D-1:0]  busy,
  output logic             cmp_busy
);

  localparam int         NREG      = 2**D;
  localparam logic [2:0] STARVE_TH = 3'(STARVE);

  logic [2:0]      starve_cnt;
  logic            alu_prio;
  logic [NREG-1:0] busy_next;

  // Grant logic: mem wins by default, ALU wins once it has starved long enough.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    alu_prio  = (starve_cnt >= STARVE_TH);
    if (!reset) begin
      if (mem_valid && !(alu_valid && alu_prio)) begin
        mem_ready = 1'b1;
      end else if (alu_valid) begin
        alu_ready = 1'b1;
      end
    end
  end

  // Starvation counter: counts ALU's consecutive lost cycles, saturating at 7.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 3'd0;
    end else if (alu_valid && !alu_ready) begin
      starve_cnt <= (starve_cnt == 3'd7) ? 3'd7 : starve_cnt + 3'd1;
    end else begin
      starve_cnt <= 3'd0;
    end
  end

  // Output stage: register the accepted request; writes to r0 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_en <= 1'b0;
      rf_w_addr   <= '0;
      rf_data_in  <= '0;
    end else if (alu_ready) begin
      rf_write_en <= (alu_addr != '0);
      rf_w_addr   <= alu_addr;
      rf_data_in  <= alu_data;
    end else if (mem_ready) begin
      rf_write_en <= (mem_addr != '0);
      rf_w_addr   <= mem_addr;
      rf_data_in  <= mem_data;
    end else begin
      rf_write_en <= 1'b0;
    end
  end

  // Scoreboard next state: clear on write-back, then set on claim so set wins.
  always_comb begin
    busy_next = busy;
    if (rf_write_en) begin
      busy_next[rf_w_addr] = 1'b0;
    end
    if (claim_en && (claim_addr != '0)) begin
      busy_next[claim_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Branch stall on the comparison register.
  assign cmp_busy = busy[NREG-1];

endmodule
